// File: rtl/sigmoid_pla_pipe.sv
// sigmoid_pla_pipe: three-stage streaming piecewise-linear sigmoid / tanh unit.
// Operands and results are signed fixed point Q(DATA_W-FRAC_W).FRAC_W.
// Stage 1 takes |x| (doubled for tanh), stage 2 evaluates the PLAN segment,
// and stage 3 applies the sign mirror and the tanh rescale.
// All stages advance together whenever the output slot is free or is being consumed.

module sigmoid_pla_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    // Fixed-point constants
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_W;
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    // Segment thresholds: 1.0, 2.375, 5.0
    localparam logic [DATA_W-1:0] T1 = ONE;
    localparam logic [DATA_W-1:0] T2 = (ONE << 1) + (ONE >> 2) + (ONE >> 3);
    localparam logic [DATA_W-1:0] T3 = (ONE << 2) + ONE;
    // Segment intercepts: 0.5, 0.625, 0.84375
    localparam logic [DATA_W-1:0] B0 = ONE >> 1;
    localparam logic [DATA_W-1:0] B1 = (ONE >> 1) + (ONE >> 3);
    localparam logic [DATA_W-1:0] B2 = (ONE >> 1) + (ONE >> 2) + (ONE >> 4) + (ONE >> 5);
    // Saturation limit and LSB in the widened (DATA_W+1) domain
    localparam logic [DATA_W:0]   MAX_POS_EXT = {1'b0, MAX_POS};
    localparam logic [DATA_W:0]   LSB_EXT     = (DATA_W + 1)'(1);

    // Pipeline control
    logic adv;

    // Stage 1 registers
    logic              v1_q;
    logic              s1_q;
    logic              m1_q;
    logic [DATA_W-1:0] a1_q;

    // Stage 2 registers
    logic              v2_q;
    logic              s2_q;
    logic              m2_q;
    logic [DATA_W-1:0] y2_q;

    // Stage 3 registers
    logic              v3_q;
    logic [DATA_W-1:0] out_q;

    // Next-state values
    logic [DATA_W:0]   x_ext;
    logic [DATA_W:0]   mag_ext;
    logic [DATA_W:0]   dbl_ext;
    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] a1_d;
    logic [DATA_W-1:0] y2_d;
    logic [DATA_W-1:0] y_sym;
    logic [DATA_W-1:0] out_d;

    // Handshake: everything moves when the output register is empty or draining
    always_comb begin
        adv       = !v3_q || out_ready;
        in_ready  = adv;
        out_valid = v3_q;
        out_data  = out_q;
        busy      = v1_q || v2_q || v3_q;
    end

    // Stage 1 combinational: magnitude with one extra bit so the most-negative
    // operand cannot wrap, then saturating doubling for tanh
    always_comb begin
        x_ext   = {in_data[DATA_W-1], in_data};
        mag_ext = x_ext;
        if (in_data[DATA_W-1]) begin
            mag_ext = ~x_ext + LSB_EXT;
        end
        mag = (mag_ext > MAX_POS_EXT) ? MAX_POS : mag_ext[DATA_W-1:0];

        dbl_ext = {mag, 1'b0};
        a1_d    = mag;
        if (in_mode) begin
            a1_d = (dbl_ext > MAX_POS_EXT) ? MAX_POS : dbl_ext[DATA_W-1:0];
        end
    end

    // Stage 2 combinational: segment select; boundaries fall into the upper segment.
    // a1_q is non-negative, so a logical shift is the floor of the division.
    always_comb begin
        y2_d = ONE;
        if (a1_q < T1) begin
            y2_d = (a1_q >> 2) + B0;
        end else if (a1_q < T2) begin
            y2_d = (a1_q >> 3) + B1;
        end else if (a1_q < T3) begin
            y2_d = (a1_q >> 5) + B2;
        end
    end

    // Stage 3 combinational: mirror for negative x, then rescale for tanh.
    // y lies in [0, ONE] and 2*ONE fits the integer part, so nothing wraps.
    always_comb begin
        y_sym = s2_q ? (ONE - y2_q) : y2_q;
        out_d = m2_q ? ((y_sym << 1) - ONE) : y_sym;
    end

    // Stage valid bits: shift together on advance, hold while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    // Stage 1 payload: sign, mode and (scaled) magnitude
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            m1_q <= 1'b0;
            a1_q <= '0;
        end else if (adv && in_valid) begin
            s1_q <= in_data[DATA_W-1];
            m1_q <= in_mode;
            a1_q <= a1_d;
        end
    end

    // Stage 2 payload: sign, mode and half-plane result y in [0.5, 1.0]
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_q <= 1'b0;
            m2_q <= 1'b0;
            y2_q <= '0;
        end else if (adv && v1_q) begin
            s2_q <= s1_q;
            m2_q <= m1_q;
            y2_q <= y2_d;
        end
    end

    // Output register: only loaded by a real entry, so it never shows bubble data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
        end else if (adv && v2_q) begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_sigmoid_pla_pipe.sv
// tb_sigmoid_pla_pipe: self-checking bench for sigmoid_pla_pipe in Q16.16.
// Directed points, latency, streaming, backpressure and reset scenarios, plus a
// randomized stream scored against an arithmetic reference model.

module tb_sigmoid_pla_pipe;

    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    int n_checks;
    int n_fail;

    logic [DW-1:0] exp_q[$];

    sigmoid_pla_pipe #(
        .DATA_W(32),
        .FRAC_W(16)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the real-valued segment rules, Q16.16
    function automatic logic [DW-1:0] ref_act(input logic [DW-1:0] x, input logic mode);
        longint xv, a, y, r;
        xv = longint'($signed(x));
        a  = (xv < 0) ? -xv : xv;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        if (mode) begin
            a = 2 * a;
            if (a > 64'sd2147483647) a = 64'sd2147483647;
        end
        if (a < 65536)       y = a / 4 + 32768;   // 1.0,   0.5
        else if (a < 155648) y = a / 8 + 40960;   // 2.375, 0.625
        else if (a < 327680) y = a / 32 + 55296;  // 5.0,   0.84375
        else                 y = 65536;
        if (xv < 0) y = 65536 - y;
        r = mode ? (2 * y - 65536) : y;
        return r[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_operand();
        int unsigned sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return $urandom;
        return DW'($urandom_range(0, 12 * 65536)) - DW'(6 * 65536);
    endfunction

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_data: got %h, expected 00000000", out_data);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sigmoid_points();
        logic [DW-1:0] xs [7] = '{32'h00000000, 32'h00010000, 32'hFFFF0000, 32'h00026000,
                                  32'h00060000, 32'h80000000, 32'h7FFFFFFF};
        logic [DW-1:0] ys [7] = '{32'h00008000, 32'h0000C000, 32'h00004000, 32'h0000EB00,
                                  32'h00010000, 32'h00000000, 32'h00010000};
        int cnt;
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_mode   = 1'b0;
            in_data   = xs[i];
            @(negedge clk);
            in_valid = 1'b0;
            cnt = 1;
            while (out_valid !== 1'b1 && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            n_checks++;
            if (cnt != 3) begin
                n_fail++; $display("FAIL sig_latency[%0d]: got %0d cycles, expected 3", i, cnt);
            end
            n_checks++;
            if (out_data !== ys[i]) begin
                n_fail++;
                $display("FAIL sig_point x=%h: got %h, expected %h", xs[i], out_data, ys[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tanh_points();
        logic [DW-1:0] xs [4] = '{32'h00008000, 32'hFFFF8000, 32'h00040000, 32'h00000000};
        logic [DW-1:0] ys [4] = '{32'h00008000, 32'hFFFF8000, 32'h00010000, 32'h00000000};
        int cnt;
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_mode   = 1'b1;
            in_data   = xs[i];
            @(negedge clk);
            in_valid = 1'b0;
            cnt = 1;
            while (out_valid !== 1'b1 && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            n_checks++;
            if (cnt != 3) begin
                n_fail++; $display("FAIL tanh_latency[%0d]: got %0d cycles, expected 3", i, cnt);
            end
            n_checks++;
            if (out_data !== ys[i]) begin
                n_fail++;
                $display("FAIL tanh_point x=%h: got %h, expected %h", xs[i], out_data, ys[i]);
            end
            @(negedge clk);
        end
        in_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ops [8];
        logic          mds [8];
        logic [DW-1:0] e;
        int sent, got, first_c, last_c;
        for (int i = 0; i < 8; i++) begin
            ops[i] = rand_operand();
            mds[i] = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        sent = 0; got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 30 && got < 8; c++) begin
            out_ready = 1'b1;
            in_valid  = (sent < 8);
            in_data   = (sent < 8) ? ops[sent] : '0;
            in_mode   = (sent < 8) ? mds[sent] : 1'b0;
            #1;
            if (in_valid) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_in_ready c=%0d: got %b, expected 1", c, in_ready);
                end
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got %h, expected no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++; $display("FAIL b2b_data[%0d]: got %h, expected %h", got, out_data, e);
                    end
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_act(ops[sent], mds[sent]));
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 8 || last_c - first_c != 7) begin
            n_fail++;
            $display("FAIL b2b_stream: got %0d results over %0d cycles, expected 8 over 8",
                     got, last_c - first_c + 1);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ops [4];
        logic [DW-1:0] e, held;
        int sent, got;
        for (int i = 0; i < 4; i++) ops[i] = rand_operand();
        exp_q.delete();
        sent = 0; got = 0; held = '0;
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            in_valid  = (sent < 4);
            in_data   = ops[sent < 4 ? sent : 3];
            in_mode   = 1'b0;
            #1;
            if (c >= 3) begin
                n_checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stall c=%0d: got in_ready=%b out_valid=%b, expected 0/1",
                             c, in_ready, out_valid);
                end
            end
            if (c == 3) held = out_data;
            if (c == 4) begin
                n_checks++;
                if (out_data !== held) begin
                    n_fail++; $display("FAIL bp_hold: got %h, expected %h", out_data, held);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_act(ops[sent], 1'b0));
                sent++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (sent != 3) begin
            n_fail++; $display("FAIL bp_accepted: got %0d, expected 3", sent);
        end
        for (int c = 0; c < 20 && got < 4; c++) begin
            out_ready = 1'b1;
            in_valid  = (sent < 4);
            in_data   = ops[sent < 4 ? sent : 3];
            #1;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: got %h, expected no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++; $display("FAIL bp_data[%0d]: got %h, expected %h", got, out_data, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_act(ops[sent], 1'b0));
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (got != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d results (%0d left), expected 4 (0 left)",
                     got, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] e, prev_data;
        logic          prev_stall;
        int            got, acc;
        exp_q.delete();
        prev_stall = 1'b0; prev_data = '0; got = 0; acc = 0;
        for (int c = 0; c < 460; c++) begin
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL rnd_stall_hold: got %b/%h, expected 1/%h",
                             out_valid, out_data, prev_data);
                end
            end
            out_ready = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid  = (c < 400) && ($urandom_range(0, 3) != 0);
            in_data   = rand_operand();
            in_mode   = 1'($urandom_range(0, 1));
            #1;
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra: got %h, expected no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++; $display("FAIL rnd_data[%0d]: got %h, expected %h", got, out_data, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_act(in_data, in_mode));
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || got != acc) begin
            n_fail++;
            $display("FAIL rnd_drain: got %0d results for %0d accepted, expected equal", got, acc);
        end
    endtask

    task automatic test_reset_midstream();
        int cnt;
        out_ready = 1'b1;
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h00020000;
        @(negedge clk);
        in_data   = 32'hFFFE0000;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy_before: got %b, expected 1", busy);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got out_valid=%b busy=%b, expected 0/0", out_valid, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_stale c=%0d: got out_valid=%b busy=%b, expected 0/0",
                         c, out_valid, busy);
            end
        end
        in_valid = 1'b1;
        in_data  = 32'h00010000;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 3 || out_data !== 32'h0000C000) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %h after %0d cycles, expected 0000c000 after 3",
                     out_data, cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sigmoid_points();
        test_tanh_points();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
